// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming (12,8) link: codeword width, bit positions
// of the parity bits and the receive deframer state encoding.
package hamming_pkg;

   localparam int unsigned ANCHO_CODIGO = 12;

   // Parity bit positions inside {p1,p2,d1,p3,d2,d3,d4,p4,d5,d6,d7,d8}
   localparam int unsigned P1 = 11;
   localparam int unsigned P2 = 10;
   localparam int unsigned P3 = 8;
   localparam int unsigned P4 = 4;

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      DATOS  = 2'd1,
      PARADA = 2'd2
   } estado_rx_t;

endpackage

// File: rtl/hamming_rx_deser_if.sv
// Serial input, codeword handshake and status signals of the receive front-end.
interface hamming_rx_deser_if #(
   parameter int unsigned ANCHO = hamming_pkg::ANCHO_CODIGO
);

   logic             rx_en;
   logic             rx_bit;
   logic [ANCHO-1:0] codigoH_recibido;
   logic             valido;
   logic             listo;
   logic             err_trama;
   logic             err_desborde;
   logic             ocupado;

   // Deserializer side: consumes the line, produces codewords
   modport master (
      input  rx_en,
      input  rx_bit,
      input  listo,
      output codigoH_recibido,
      output valido,
      output err_trama,
      output err_desborde,
      output ocupado
   );

   // Line driver / corrector side
   modport slave (
      output rx_en,
      output rx_bit,
      output listo,
      input  codigoH_recibido,
      input  valido,
      input  err_trama,
      input  err_desborde,
      input  ocupado
   );

endinterface

// File: rtl/hamming_buf_salida.sv
// One-entry valid/ready holding register for received codewords, with an
// overrun pulse when a new word arrives while the entry is full and not draining.
module hamming_buf_salida
   import hamming_pkg::*;
#(
   parameter int unsigned ANCHO = ANCHO_CODIGO
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             carga,
   input  logic [ANCHO-1:0] dato,
   input  logic             listo,
   output logic [ANCHO-1:0] codigo,
   output logic             valido,
   output logic             err_desborde
);

   logic transfer_c;
   logic acepta_c;

   assign transfer_c = valido && listo;
   // A same-cycle transfer frees the entry for the incoming word
   assign acepta_c   = carga && (!valido || listo);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         codigo       <= '0;
         valido       <= 1'b0;
         err_desborde <= 1'b0;
      end else begin
         err_desborde <= carga && !acepta_c;
         if (acepta_c) begin
            codigo <= dato;
            valido <= 1'b1;
         end else if (transfer_c) begin
            valido <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/hamming_rx_deser.sv
// Serial receive front-end: deframes start/data/stop frames into 12-bit
// codewords and hands them to the corrector through a one-entry buffer.
module hamming_rx_deser
   import hamming_pkg::*;
#(
   parameter int unsigned ANCHO = ANCHO_CODIGO
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hamming_rx_deser_if.master   bus
);

   localparam int unsigned CW = $clog2(ANCHO + 1);

   estado_rx_t       estado;
   estado_rx_t       estado_sig;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_sig;
   logic [ANCHO-1:0] sr;
   logic [ANCHO-1:0] sr_sig;
   logic             carga_c;
   logic             trama_mala_c;
   logic             ultimo_bit_c;

   assign ultimo_bit_c = (cnt == CW'(ANCHO - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= REPOSO;
      end else begin
         estado <= estado_sig;
      end
   end

   // Next-state logic; only strobe cycles advance the frame
   always_comb begin
      estado_sig = estado;
      case (estado)
         REPOSO: if (bus.rx_en && !bus.rx_bit) estado_sig = DATOS;
         DATOS:  if (bus.rx_en && ultimo_bit_c) estado_sig = PARADA;
         PARADA: if (bus.rx_en)                 estado_sig = REPOSO;
         default:                               estado_sig = REPOSO;
      endcase
   end

   // Per-state datapath updates and stop-bit verdict
   always_comb begin
      cnt_sig      = cnt;
      sr_sig       = sr;
      carga_c      = 1'b0;
      trama_mala_c = 1'b0;
      case (estado)
         REPOSO: begin
            if (bus.rx_en && !bus.rx_bit) cnt_sig = '0;
         end
         DATOS: begin
            if (bus.rx_en) begin
               sr_sig  = {sr[ANCHO-2:0], bus.rx_bit};
               cnt_sig = cnt + CW'(1);
            end
         end
         PARADA: begin
            if (bus.rx_en) begin
               carga_c      = bus.rx_bit;
               trama_mala_c = !bus.rx_bit;
            end
         end
         default: begin
            cnt_sig = '0;
         end
      endcase
   end

   // Counter, shift register and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         sr            <= '0;
         bus.err_trama <= 1'b0;
         bus.ocupado   <= 1'b0;
      end else begin
         cnt           <= cnt_sig;
         sr            <= sr_sig;
         bus.err_trama <= trama_mala_c;
         bus.ocupado   <= (estado_sig != REPOSO);
      end
   end

   hamming_buf_salida #(
      .ANCHO (ANCHO)
   ) u_buf_salida (
      .clk          (clk),
      .rst_n        (rst_n),
      .carga        (carga_c),
      .dato         (sr),
      .listo        (bus.listo),
      .codigo       (bus.codigoH_recibido),
      .valido       (bus.valido),
      .err_desborde (bus.err_desborde)
   );

endmodule

// File: tb/tb_hamming_rx_deser.sv
// Directed bench for hamming_rx_deser: expected codewords are queued when a
// frame is sent and matched against every valid/ready transfer.
module tb_hamming_rx_deser;
   import hamming_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   hamming_rx_deser_if bus ();

   hamming_rx_deser dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n_trama = 0;
   int n_desb = 0;
   logic [11:0] exp_q[$];
   logic        prev_v = 1'b0;
   logic        prev_x = 1'b0;
   logic [11:0] prev_c = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard and protocol monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.err_trama)    n_trama++;
         if (bus.err_desborde) n_desb++;
         if (prev_v && !prev_x) begin
            check("valido_mantiene", 32'(bus.valido), 32'd1);
            check("codigo_estable", 32'(bus.codigoH_recibido), 32'(prev_c));
         end
         if (bus.valido && bus.listo) begin
            if (exp_q.size() == 0)
               check("transfer_sin_esperado", 32'(exp_q.size()), 32'd1);
            else
               check("transfer_dato", 32'(bus.codigoH_recibido), 32'(exp_q.pop_front()));
         end
         prev_v = bus.valido;
         prev_x = bus.valido && bus.listo;
         prev_c = bus.codigoH_recibido;
      end else begin
         prev_v = 1'b0;
         prev_x = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int gap);
      repeat (gap) begin
         tick();
         bus.rx_en  = 1'b0;
         bus.rx_bit = 1'b1;
      end
      tick();
      bus.rx_en  = 1'b1;
      bus.rx_bit = b;
   endtask

   // Returns during the stop-bit strobe cycle
   task automatic send_frame(input logic [11:0] w, input logic stop, input int gap);
      send_bit(1'b0, gap);
      for (int i = 11; i >= 0; i--) send_bit(w[i], gap);
      send_bit(stop, gap);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         bus.rx_en  = 1'b0;
         bus.rx_bit = 1'b1;
      end
   endtask

   initial begin
      logic [11:0] w;
      bus.rx_en  = 1'b0;
      bus.rx_bit = 1'b1;
      bus.listo  = 1'b1;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_codigo", 32'(bus.codigoH_recibido), 32'h0);
      check("rst_valido", 32'(bus.valido), 32'd0);
      check("rst_err_trama", 32'(bus.err_trama), 32'd0);
      check("rst_err_desborde", 32'(bus.err_desborde), 32'd0);
      check("rst_ocupado", 32'(bus.ocupado), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Back-to-back strobes, listo held high: valid for one cycle, 14 after start
      exp_q.push_back(12'hB3C);
      send_frame(12'hB3C, 1'b1, 0);
      check("t1_valido_en_parada", 32'(bus.valido), 32'd0);
      check("t1_ocupado_en_parada", 32'(bus.ocupado), 32'd1);
      idle(1);
      check("t1_valido", 32'(bus.valido), 32'd1);
      check("t1_dato", 32'(bus.codigoH_recibido), 32'hB3C);
      check("t1_ocupado_fin", 32'(bus.ocupado), 32'd0);
      idle(1);
      check("t1_un_ciclo", 32'(bus.valido), 32'd0);
      idle(2);

      // Strobe every 4th cycle, with a long stall after the start bit
      w = 12'hB3C;
      exp_q.push_back(w);
      send_bit(1'b0, 3);
      idle(5);
      check("t2_ocupado_retiene", 32'(bus.ocupado), 32'd1);
      for (int i = 11; i >= 0; i--) send_bit(w[i], 3);
      send_bit(1'b1, 3);
      idle(1);
      check("t2_valido", 32'(bus.valido), 32'd1);
      check("t2_dato", 32'(bus.codigoH_recibido), 32'hB3C);
      idle(3);
      check("t2_vacio", 32'(bus.valido), 32'd0);

      // Bad stop bit
      send_frame(12'h5A5, 1'b0, 0);
      idle(1);
      check("t3_err_trama", 32'(bus.err_trama), 32'd1);
      check("t3_valido", 32'(bus.valido), 32'd0);
      check("t3_ocupado", 32'(bus.ocupado), 32'd0);
      idle(1);
      check("t3_pulso", 32'(bus.err_trama), 32'd0);
      idle(2);

      // Overrun: second word dropped while the first waits
      bus.listo = 1'b0;
      exp_q.push_back(12'h123);
      send_frame(12'h123, 1'b1, 0);
      idle(2);
      check("t4_valido", 32'(bus.valido), 32'd1);
      check("t4_dato", 32'(bus.codigoH_recibido), 32'h123);
      send_frame(12'hFED, 1'b1, 0);
      idle(1);
      check("t4_err_desborde", 32'(bus.err_desborde), 32'd1);
      check("t4_valido_lleno", 32'(bus.valido), 32'd1);
      check("t4_dato_viejo", 32'(bus.codigoH_recibido), 32'h123);
      idle(1);
      check("t4_pulso", 32'(bus.err_desborde), 32'd0);
      bus.listo = 1'b1;
      idle(1);
      check("t4_vaciado", 32'(bus.valido), 32'd0);
      check("t4_dato_retenido", 32'(bus.codigoH_recibido), 32'h123);
      idle(2);

      // Stop strobe coincides with a transfer: new word loads, no overrun
      bus.listo = 1'b0;
      exp_q.push_back(12'h123);
      send_frame(12'h123, 1'b1, 0);
      idle(2);
      exp_q.push_back(12'hFED);
      send_frame(12'hFED, 1'b1, 0);
      bus.listo = 1'b1;
      idle(1);
      check("t5_valido", 32'(bus.valido), 32'd1);
      check("t5_dato", 32'(bus.codigoH_recibido), 32'hFED);
      check("t5_sin_desborde", 32'(bus.err_desborde), 32'd0);
      idle(1);
      check("t5_vaciado", 32'(bus.valido), 32'd0);
      idle(2);

      // Asynchronous reset mid-frame with a word pending
      bus.listo = 1'b0;
      exp_q.push_back(12'h0AA);
      send_frame(12'h0AA, 1'b1, 0);
      idle(2);
      w = 12'hF0F;
      send_bit(1'b0, 0);
      for (int i = 11; i >= 6; i--) send_bit(w[i], 0);
      idle(1);
      check("t6_ocupado_previo", 32'(bus.ocupado), 32'd1);
      check("t6_valido_previo", 32'(bus.valido), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_codigo", 32'(bus.codigoH_recibido), 32'h0);
      check("t6_rst_valido", 32'(bus.valido), 32'd0);
      check("t6_rst_ocupado", 32'(bus.ocupado), 32'd0);
      check("t6_rst_err_trama", 32'(bus.err_trama), 32'd0);
      check("t6_rst_err_desborde", 32'(bus.err_desborde), 32'd0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      bus.listo = 1'b1;
      idle(2);
      exp_q.push_back(12'h0FF);
      send_frame(12'h0FF, 1'b1, 0);
      idle(1);
      check("t6_valido", 32'(bus.valido), 32'd1);
      check("t6_dato", 32'(bus.codigoH_recibido), 32'h0FF);
      idle(3);

      check("cola_vacia", 32'(exp_q.size()), 32'd0);
      check("total_err_trama", 32'(n_trama), 32'd1);
      check("total_err_desborde", 32'(n_desb), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
